alarm_sequencer: RTL and testbench
==================================

# alarm_sequencer

Controller that decides when the alarm sound plays and streams the stored audio clip to the PDM output stage. It watches the BCD time-of-day bus against the alarm setting and a snooze target. When either matches, it reads the sample ROM at the audio sample rate and repeats the clip a fixed number of times. It also handles stop and snooze. It sits between the timekeeping counter / alarm register and the sample ROM plus PDM modulator.

## Interface
- CLK_HZ, 50000000, system clock frequency
- SAMPLE_HZ, 8000, playback rate; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥4)
- NUM_SAMPLES, 19832, clip length in samples
- ADDR_W, 15, ROM address width (2^ADDR_W ≥ NUM_SAMPLES)
- REPEATS, 3, clip plays per trigger (1..15)
- SNOOZE_MIN, 5, snooze delay in minutes (1..9)

- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- time_bcd  in  32  current time, BCD: [31:28] hour tens, [27:24] hour units, [23:20]/[19:16] minutes, [15:12]/[11:8] seconds, [7:4]/[3:0] hundredths
- alarm_bcd  in  32  alarm setting, same format
- alarm_enable  in  1  level; 0 forces IDLE
- stop  in  1  single-cycle pulse, synchronous
- snooze  in  1  single-cycle pulse, synchronous
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  16  signed Q1.14 sample, valid the cycle after rom_rd
- sample_out  out  16  signed sample to PDM stage
- sample_valid  out  1  one-cycle pulse when sample_out updates
- playing  out  1  high in PLAY
- snoozed  out  1  high in SNOOZE

## Operation
- States: IDLE, WAIT, PLAY, SNOOZE.
- IDLE: when alarm_enable=1, go to WAIT on the next cycle.
- WAIT: register match_q = (time_bcd == alarm_bcd). Trigger only on the rising edge (match & !match_q). On trigger, go to PLAY with repeat_cnt=0, rom_addr=0, tick_cnt=0.
- PLAY:
  - tick_cnt counts 0..DIV-1 and wraps.
  - When tick_cnt==0, assert rom_rd with the current rom_addr.
  - On the following cycle, sample_out<=rom_data and sample_valid=1.
  - After the read of address NUM_SAMPLES-1, set rom_addr=0 and increment repeat_cnt. If repeat_cnt reaches REPEATS, go to WAIT after that last sample has been delivered.
- PLAY + snooze: go to SNOOZE and latch the snooze target.
  - Target = time_bcd at the snooze cycle, with SNOOZE_MIN added to the minutes in BCD.
  - Minutes carry into hours: 59→00 with hour +1.
  - Hours wrap 23→00.
  - Seconds and hundredths are copied unchanged.
- PLAY + stop: go to WAIT.
- SNOOZE:
  - alarm_bcd is ignored.
  - Trigger on the rising edge of (time_bcd == target); this restarts PLAY with repeat_cnt=0.
  - stop goes to WAIT.
- Any state, alarm_enable=0: go to IDLE.
- Priority within one cycle: reset > alarm_enable=0 > stop > snooze > match/clip-end.
- snooze outside PLAY is ignored. stop in WAIT/IDLE is ignored.
- Leaving PLAY for any reason:
  - sample_out<=0 the next cycle, with no sample_valid.
  - Any read already issued is discarded.
- match_q updates every cycle in every state, so a stop during an ongoing equal time does not retrigger.

## Timing
- Reset values: state=IDLE, rom_rd=0, rom_addr=0, sample_out=0, sample_valid=0, playing=0, snoozed=0, match_q=0, repeat_cnt=0, tick_cnt=0.
- Trigger edge detected in cycle N: playing=1 and first rom_rd in cycle N+1; first sample_valid in N+2.
- rom_rd period = DIV cycles. sample_valid always lags rom_rd by exactly 1 cycle.
- Between repeats, address N-1 is followed by address 0 exactly DIV cycles later (no gap).
- Last sample of the final repeat: sample_valid fires, and playing drops the same cycle.
- Snooze target is latched in the snooze cycle; snoozed=1 the next cycle.
- Reset asserted mid-PLAY: all outputs go to reset values immediately (asynchronously).

## Test plan
All scenarios use CLK_HZ=80, SAMPLE_HZ=8 (DIV=10), NUM_SAMPLES=4, REPEATS=2, SNOOZE_MIN=5, ROM[i]=0x1000+i.

- alarm_bcd=0x07300000, enable=1, time steps 0x07295999→0x07300000 → rom_rd 1 cycle later. Addresses 0,1,2,3,0,1,2,3, each 10 cycles apart. sample_out 0x1000..0x1003 twice. Then playing=0, state WAIT.
- Hold time=0x07300000 for 200 cycles after the clip ends → no retrigger. Step time away and back → retrigger.
- Snooze during PLAY with time=0x23581234 → snoozed=1, sample_out=0. Target 0x00031234: time 0x00031233 does not trigger; 0x00031234 restarts PLAY from address 0.
- Snooze with time=0x09070000 → target 0x09120000. stop in SNOOZE → WAIT, no play at 0x09120000.
- stop and snooze in the same cycle during PLAY → WAIT (stop wins).
- Assert reset during PLAY, and deassert alarm_enable during PLAY → reset: all outputs 0 immediately. enable low: IDLE next cycle, sample_out=0, no further rom_rd.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm playback controller: watches BCD time against the alarm/snooze target and
// streams the stored clip from the sample ROM at the audio sample rate.
module alarm_sequencer #(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_HZ   = 8000,
  parameter int NUM_SAMPLES = 19832,
  parameter int ADDR_W      = 15,
  parameter int REPEATS     = 3,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [31:0]              time_bcd,
  input  logic [31:0]              alarm_bcd,
  input  logic                     alarm_enable,
  input  logic                     stop,
  input  logic                     snooze,
  output logic                     rom_rd,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [15:0]       rom_data,
  output logic signed [15:0]       sample_out,
  output logic                     sample_valid,
  output logic                     playing,
  output logic                     snoozed
);

  localparam int DATA_W = 16;
  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PLAY,
    S_SNOOZE
  } state_t;

  state_t state, state_next;

  logic [TICK_W-1:0]        tick_cnt;
  logic [3:0]               repeat_cnt;
  logic                     match_q;
  logic                     snz_match_q;
  logic [31:0]              target;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] sample_p1;

  logic alarm_match, snz_match, trig_alarm, trig_snz;
  logic rd, last_rd, start_play, vld_d;

  // Add SNOOZE_MIN minutes to a BCD time, carrying into hours and wrapping at 24h.
  function automatic logic [31:0] add_snooze(input logic [31:0] t);
    logic [7:0] mins;
    logic [7:0] hrs;
    mins = 8'(t[23:20]) * 8'd10 + 8'(t[19:16]) + 8'(SNOOZE_MIN);
    hrs  = 8'(t[31:28]) * 8'd10 + 8'(t[27:24]);
    if (mins >= 8'd60) begin
      mins = mins - 8'd60;
      hrs  = (hrs >= 8'd23) ? 8'd0 : hrs + 8'd1;
    end
    return {4'(hrs / 8'd10), 4'(hrs % 8'd10), 4'(mins / 8'd10), 4'(mins % 8'd10), t[15:0]};
  endfunction

  assign alarm_match = (time_bcd == alarm_bcd);
  assign snz_match   = (time_bcd == target);
  assign trig_alarm  = alarm_match && !match_q;
  assign trig_snz    = snz_match && !snz_match_q;
  assign rd          = (state == S_PLAY) && (tick_cnt == '0);
  assign last_rd     = rd && (rom_addr == ADDR_W'(NUM_SAMPLES - 1))
                          && (repeat_cnt == 4'(REPEATS - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_play = 1'b0;
    vld_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (alarm_enable) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (trig_alarm) begin
          state_next = S_PLAY;
          start_play = 1'b1;
        end
      end
      S_PLAY: begin
        vld_d = rd;
        if (stop) begin
          state_next = S_WAIT;
          vld_d      = 1'b0;
        end else if (snooze) begin
          state_next = S_SNOOZE;
          vld_d      = 1'b0;
        end else if (last_rd) begin
          // The final read still completes; only aborts drop the pending read.
          state_next = S_WAIT;
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          state_next = S_WAIT;
        end else if (trig_snz) begin
          state_next = S_PLAY;
          start_play = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (!alarm_enable) begin
      state_next = S_IDLE;
      start_play = 1'b0;
      vld_d      = 1'b0;
    end
  end

  assign rom_rd  = rd;
  assign playing = (state == S_PLAY);
  assign snoozed = (state == S_SNOOZE);

  // Stage p0: sample-rate tick, ROM address and repeat bookkeeping
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt    <= '0;
      rom_addr    <= '0;
      repeat_cnt  <= '0;
      match_q     <= 1'b0;
      snz_match_q <= 1'b0;
    end else begin
      match_q     <= alarm_match;
      snz_match_q <= snz_match;
      if (start_play) begin
        tick_cnt   <= '0;
        rom_addr   <= '0;
        repeat_cnt <= '0;
      end else if (state == S_PLAY) begin
        tick_cnt <= (tick_cnt == TICK_W'(DIV - 1)) ? '0 : tick_cnt + 1'b1;
        if (rd) begin
          if (rom_addr == ADDR_W'(NUM_SAMPLES - 1)) begin
            rom_addr   <= '0;
            repeat_cnt <= repeat_cnt + 4'd1;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (state == S_PLAY && state_next == S_SNOOZE) target <= add_snooze(time_bcd);
  end

  // Stage p1: ROM data returns; the output mux shows it in the same cycle as the valid pulse
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      sample_p1 <= '0;
    end else begin
      vld_p1 <= vld_d;
      if (state_next != S_PLAY) sample_p1 <= '0;
      else if (vld_p1)          sample_p1 <= rom_data;
    end
  end

  assign sample_valid = vld_p1;
  assign sample_out   = vld_p1 ? rom_data : sample_p1;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: DIV=10, 4-sample clip played twice, ROM[i]=0x1000+i.
module tb_alarm_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        time_bcd;
  logic [31:0]        alarm_bcd;
  logic               alarm_enable;
  logic               stop;
  logic               snooze;
  logic               rom_rd;
  logic [14:0]        rom_addr;
  logic signed [15:0] rom_data = '0;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               playing;
  logic               snoozed;

  int n_cmp  = 0;
  int n_fail = 0;

  alarm_sequencer #(
    .CLK_HZ(80), .SAMPLE_HZ(8), .NUM_SAMPLES(4), .ADDR_W(15), .REPEATS(2), .SNOOZE_MIN(5)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .time_bcd(time_bcd), .alarm_bcd(alarm_bcd),
    .alarm_enable(alarm_enable), .stop(stop), .snooze(snooze), .rom_rd(rom_rd),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .playing(playing), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) rom_data <= 16'h1000 + 16'(rom_addr);

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  function automatic logic [34:0] pk(input logic rd, input logic [14:0] a, input logic v,
                                     input logic [15:0] s, input logic p, input logic z);
    return {rd, rd ? a : 15'd0, v, s, p, z};
  endfunction

  task automatic chk(input string nm, input logic [34:0] exp);
    logic [34:0] act;
    act = pk(rom_rd, rom_addr, sample_valid, sample_out, playing, snoozed);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rd,addr,vld,smp,play,snz}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] tm;
    logic        en;
    int          adv;
    logic        rd;
    logic [14:0] addr;
    logic        vld;
    logic [15:0] smp;
    logic        play;
    logic        snz;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int rd_seen;
    vecs[0]  = '{32'h07295999, 1'b1, 3,   1'b0, 15'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{32'h07300000, 1'b1, 1,   1'b1, 15'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1000, 1'b1, 1'b0};
    vecs[3]  = '{32'h07300000, 1'b1, 9,   1'b1, 15'd1, 1'b0, 16'h1000, 1'b1, 1'b0};
    vecs[4]  = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1001, 1'b1, 1'b0};
    vecs[5]  = '{32'h07300000, 1'b1, 19,  1'b1, 15'd3, 1'b0, 16'h1002, 1'b1, 1'b0};
    vecs[6]  = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1003, 1'b1, 1'b0};
    vecs[7]  = '{32'h07300000, 1'b1, 9,   1'b1, 15'd0, 1'b0, 16'h1003, 1'b1, 1'b0};
    vecs[8]  = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1000, 1'b1, 1'b0};
    vecs[9]  = '{32'h07300000, 1'b1, 29,  1'b1, 15'd3, 1'b0, 16'h1002, 1'b1, 1'b0};
    vecs[10] = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1003, 1'b0, 1'b0};
    vecs[11] = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{32'h07300000, 1'b1, 200, 1'b0, 15'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{32'h07300001, 1'b1, 2,   1'b0, 15'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{32'h07300000, 1'b1, 1,   1'b1, 15'd0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{32'h07300000, 1'b1, 1,   1'b0, 15'd0, 1'b1, 16'h1000, 1'b1, 1'b0};

    reset = 1'b1; time_bcd = '0; alarm_bcd = 32'h07300000;
    alarm_enable = 1'b0; stop = 1'b0; snooze = 1'b0;
    cyc(2);
    chk("reset_state", pk(0, 0, 0, 16'h0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      time_bcd     = vecs[i].tm;
      alarm_enable = vecs[i].en;
      cyc(vecs[i].adv);
      chk($sformatf("vec%0d", i),
          pk(vecs[i].rd, vecs[i].addr, vecs[i].vld, vecs[i].smp, vecs[i].play, vecs[i].snz));
    end

    // Snooze across midnight: 23:58 + 5 min -> 00:03
    time_bcd = 32'h23581234; snooze = 1'b1;
    cyc(1); snooze = 1'b0;
    chk("snooze_enter", pk(0, 0, 0, 16'h0, 0, 1));
    time_bcd = 32'h00031233;
    cyc(3);
    chk("snooze_early", pk(0, 0, 0, 16'h0, 0, 1));
    time_bcd = 32'h00031234;
    cyc(1);
    chk("snooze_wake", pk(1, 0, 0, 16'h0, 1, 0));
    cyc(1);
    chk("snooze_wake_smp", pk(0, 0, 1, 16'h1000, 1, 0));

    // Snooze then stop: target 09:12 must not play
    time_bcd = 32'h09070000; snooze = 1'b1;
    cyc(1); snooze = 1'b0;
    chk("snooze2_enter", pk(0, 0, 0, 16'h0, 0, 1));
    stop = 1'b1;
    cyc(1); stop = 1'b0;
    chk("snooze_stop", pk(0, 0, 0, 16'h0, 0, 0));
    time_bcd = 32'h09120000;
    cyc(3);
    chk("snooze_stopped_target", pk(0, 0, 0, 16'h0, 0, 0));
    alarm_bcd = 32'h09130000; time_bcd = 32'h09130000;
    cyc(1);
    chk("wait_after_stop", pk(1, 0, 0, 16'h0, 1, 0));

    // stop and snooze together on a read cycle: stop wins, read discarded
    stop = 1'b1; snooze = 1'b1;
    cyc(1); stop = 1'b0; snooze = 1'b0;
    chk("stop_beats_snooze", pk(0, 0, 0, 16'h0, 0, 0));
    cyc(20);
    chk("no_retrigger_after_stop", pk(0, 0, 0, 16'h0, 0, 0));

    // Asynchronous reset mid-play
    time_bcd = 32'h09130001;
    cyc(1); time_bcd = 32'h09130000;
    cyc(1);
    chk("replay_start", pk(1, 0, 0, 16'h0, 1, 0));
    cyc(1);
    #2 reset = 1'b1;
    #1 chk("async_reset", pk(0, 0, 0, 16'h0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Enable dropped during play
    time_bcd = 32'h09130001;
    cyc(3); time_bcd = 32'h09130000;
    cyc(1);
    chk("post_reset_play", pk(1, 0, 0, 16'h0, 1, 0));
    cyc(1);
    chk("post_reset_smp", pk(0, 0, 1, 16'h1000, 1, 0));
    alarm_enable = 1'b0;
    cyc(1);
    chk("enable_low", pk(0, 0, 0, 16'h0, 0, 0));
    rd_seen = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (rom_rd) rd_seen++;
    end
    n_cmp++;
    if (rd_seen != 0) begin
      n_fail++;
      $display("FAIL enable_low_no_rd: got %0d reads expected 0", rd_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
